// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared types and sizing helpers for the nibble-serial adder
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Keeps the nibble counter at least one bit wide when only one nibble exists.
  function automatic int cnt_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/AdderAhead_4.sv
// rtl/AdderAhead_4.sv - 4-bit carry-lookahead adder slice with group generate/propagate
module AdderAhead_4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o,
  output logic       g_o,
  output logic       p_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & cin_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);

  assign g_o    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign p_o    = &p;
  assign cout_o = g_o | (p_o & cin_i);
  assign sum_o  = p ^ c;

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-cycle adder, one nibble per clock, LSB nibble first
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CW = cnt_width(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_e state_q, state_d;
  logic   accept;

  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             a_msb_q, b_msb_q;

  logic [NIBBLE_W-1:0] nib;
  logic                nib_cout;
  logic [WIDTH+3:0]    sum_cat;

  AdderAhead_4 u_slice (
    .a_i    (a_q[NIBBLE_W-1:0]),
    .b_i    (b_q[NIBBLE_W-1:0]),
    .cin_i  (carry_q),
    .sum_o  (nib),
    .cout_o (nib_cout),
    .g_o    (),
    .p_o    ()
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        accept  = start_i;
        state_d = start_i ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Result nibbles enter at the top so the LSB nibble lands at bit 0 after the last shift.
  assign sum_cat = {nib, sum_q};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else if (accept) begin
      a_q     <= a_i;
      b_q     <= b_i;
      carry_q <= cin_i;
      cnt_q   <= '0;
      a_msb_q <= a_i[WIDTH-1];
      b_msb_q <= b_i[WIDTH-1];
    end else if (state_q == ST_RUN) begin
      a_q     <= a_q >> NIBBLE_W;
      b_q     <= b_q >> NIBBLE_W;
      sum_q   <= sum_cat[WIDTH+3:NIBBLE_W];
      carry_q <= nib_cout;
      cnt_q   <= cnt_q + CW'(1);
    end
  end

  assign busy_o = (state_q == ST_RUN);
  assign done_o = (state_q == ST_DONE);
  assign sum_o  = sum_q;
  assign cout_o = carry_q;
  assign ovf_o  = (a_msb_q == b_msb_q) && (sum_q[WIDTH-1] != a_msb_q);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             busy, done, cout, ovf;
  logic [WIDTH-1:0] sum;

  int checks   = 0;
  int failures = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .cin_i   (cin),
    .busy_o  (busy),
    .done_o  (done),
    .sum_o   (sum),
    .cout_o  (cout),
    .ovf_o   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: an accepted operation resolves NIBBLES edges later into a full-width sum.
  int               m_left;
  logic             m_done, m_cout, m_ovf, p_cout, p_ovf;
  logic [WIDTH-1:0] m_sum, p_sum;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_sum  = '0;
      m_cout = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_sum  = p_sum;
          m_cout = p_cout;
          m_ovf  = p_ovf;
        end
      end else if (start) begin
        {p_cout, p_sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        p_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (p_sum[WIDTH-1] != a[WIDTH-1]);
        m_left = NIBBLES;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_busy", {31'd0, busy}, {31'd0, m_left > 0});
    chk("model_done", {31'd0, done}, {31'd0, m_done});
    if (m_left == 0) begin
      chk("model_sum", {16'd0, sum}, {16'd0, m_sum});
      chk("model_cout", {31'd0, cout}, {31'd0, m_cout});
      chk("model_ovf", {31'd0, ovf}, {31'd0, m_ovf});
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Called at a negedge right after start was dropped; returns edges from accept to done.
  task automatic wait_done(output int n, output int nb);
    n  = 1;
    nb = busy ? 1 : 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (busy) nb++;
    end
  endtask

  task automatic op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tc,
                    input logic [WIDTH-1:0] es, input logic ec, input logic eo, input string nm);
    int n, nb;
    wait_idle();
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, nb);
    chk({nm, "_latency"}, 32'(n - 1), 32'(NIBBLES));
    chk({nm, "_busy_cycles"}, 32'(nb), 32'(NIBBLES));
    chk({nm, "_sum"}, {16'd0, sum}, {16'd0, es});
    chk({nm, "_cout"}, {31'd0, cout}, {31'd0, ec});
    chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    @(negedge clk);
    chk({nm, "_done_width"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n, nb;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_sum", {16'd0, sum}, 32'd0);
    chk("reset_cout_ovf", {30'd0, cout, ovf}, 32'd0);

    op(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, "zero");
    op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, "carry_chain");
    op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "wrap");
    op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "pos_ovf");
    op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "neg_ovf");

    wait_idle();
    a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ignore_start_sum", {16'd0, sum}, 32'h2345);
    chk("ignore_start_done", {31'd0, done}, 32'd1);
    a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_no_bubble", {31'd0, busy}, 32'd1);
    wait_done(n, nb);
    chk("b2b_latency", 32'(n - 1), 32'(NIBBLES));
    chk("b2b_sum", {16'd0, sum}, 32'h1000);

    wait_idle();
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_sum", {16'd0, sum}, 32'd0);
    chk("abort_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("abort_no_done", 32'(n), 32'd0);
    op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, "after_reset");

    repeat (400) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      a     = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      b     = 16'($urandom);
      cin   = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (NIBBLES + 3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
